// File: rtl/hdd_sd_bridge_pkg.sv
// Shared definitions for the HDD-to-SD block bridge: FSM states, sector size
// and the default request timeout.
package hdd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XFER,
        DONE
    } hdd_state_t;

    localparam int          SECTOR_BYTES           = 512;
    localparam logic [23:0] TIMEOUT_CYCLES_DEFAULT = 24'd14_000_000;

endpackage

// File: rtl/hdd_sd_bridge.sv
// Turns Apple II HDD sector requests into SD block requests, steers the SD
// buffer byte stream to/from the sector RAM and tracks the mounted image.
module hdd_sd_bridge
    import hdd_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter int          SECT_W         = 16
) (
    input  logic              CLK_14M,
    input  logic              reset,
    input  logic [SECT_W-1:0] HDD_SECTOR,
    input  logic              HDD_READ,
    input  logic              HDD_WRITE,
    input  logic [7:0]        HDD_RAM_DO,
    output logic              HDD_MOUNTED,
    output logic              HDD_PROTECT,
    output logic [8:0]        HDD_RAM_ADDR,
    output logic [7:0]        HDD_RAM_DI,
    output logic              HDD_RAM_WE,
    input  logic              img_mounted,
    input  logic              img_readonly,
    input  logic [63:0]       img_size,
    output logic [31:0]       sd_lba,
    output logic              sd_rd,
    output logic              sd_wr,
    input  logic              sd_ack,
    input  logic [8:0]        sd_buff_addr,
    input  logic [7:0]        sd_buff_dout,
    output logic [7:0]        sd_buff_din,
    input  logic              sd_buff_wr,
    output logic              hdd_err
);

    hdd_state_t  state, state_next;
    logic        read_prev, write_prev, ack_prev;
    logic        read_edge, write_edge;
    logic        op_is_read, op_read_next;
    logic [23:0] timer, timer_next;
    logic [31:0] lba_next, req_lba;
    logic        rd_next, wr_next, err_next;

    // Image state survives warm reset, so these only take a power-up value.
    logic        mounted = 1'b0;
    logic        protect = 1'b0;
    logic [31:0] nsect   = 32'd0;

    logic unused_size_bits;
    assign unused_size_bits = ^{img_size[63:41], img_size[8:0]};

    assign HDD_MOUNTED = mounted;
    assign HDD_PROTECT = protect;

    always_ff @(posedge CLK_14M) begin
        if (img_mounted) begin
            mounted <= (img_size != 64'd0);
            protect <= img_readonly;
            nsect   <= img_size[40:9];
        end
    end

    assign read_edge  = HDD_READ & ~read_prev;
    assign write_edge = HDD_WRITE & ~write_prev;
    assign req_lba    = 32'(HDD_SECTOR);

    always_ff @(posedge CLK_14M) begin
        if (reset) begin
            state      <= IDLE;
            read_prev  <= 1'b0;
            write_prev <= 1'b0;
            ack_prev   <= 1'b0;
            op_is_read <= 1'b0;
            timer      <= 24'd0;
            sd_lba     <= 32'd0;
            sd_rd      <= 1'b0;
            sd_wr      <= 1'b0;
            hdd_err    <= 1'b0;
        end else begin
            state      <= state_next;
            read_prev  <= HDD_READ;
            write_prev <= HDD_WRITE;
            ack_prev   <= sd_ack;
            op_is_read <= op_read_next;
            timer      <= timer_next;
            sd_lba     <= lba_next;
            sd_rd      <= rd_next;
            sd_wr      <= wr_next;
            hdd_err    <= err_next;
        end
    end

    always_comb begin
        state_next   = state;
        op_read_next = op_is_read;
        timer_next   = timer;
        lba_next     = sd_lba;
        rd_next      = sd_rd;
        wr_next      = sd_wr;
        err_next     = hdd_err;

        case (state)
            IDLE: begin
                if (read_edge || write_edge) begin
                    // Read wins a simultaneous edge; the write is silently dropped.
                    err_next     = 1'b0;
                    lba_next     = req_lba;
                    op_read_next = read_edge;
                    if (!mounted || req_lba >= nsect) begin
                        err_next   = 1'b1;
                        state_next = DONE;
                    end else if (!read_edge && protect) begin
                        err_next   = 1'b1;
                        state_next = DONE;
                    end else begin
                        rd_next    = read_edge;
                        wr_next    = ~read_edge;
                        timer_next = TIMEOUT_CYCLES;
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                // Aborting when the counter would hit zero keeps the request
                // asserted for exactly TIMEOUT_CYCLES clocks.
                if (sd_ack) begin
                    rd_next    = 1'b0;
                    wr_next    = 1'b0;
                    state_next = XFER;
                end else if (timer <= 24'd1) begin
                    rd_next    = 1'b0;
                    wr_next    = 1'b0;
                    timer_next = 24'd0;
                    err_next   = 1'b1;
                    state_next = DONE;
                end else begin
                    timer_next = timer - 24'd1;
                end
            end
            XFER: begin
                if (ack_prev && !sd_ack) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (!HDD_READ && !HDD_WRITE) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (img_mounted && (state == REQ || state == XFER)) begin
            state_next = IDLE;
            rd_next    = 1'b0;
            wr_next    = 1'b0;
        end
    end

    assign HDD_RAM_ADDR = sd_buff_addr;
    assign HDD_RAM_DI   = sd_buff_dout;
    assign HDD_RAM_WE   = sd_buff_wr & sd_ack & (state == XFER) & op_is_read;
    assign sd_buff_din  = HDD_RAM_DO;

endmodule

// File: tb/tb_hdd_sd_bridge.sv
// Scoreboard bench for hdd_sd_bridge: expected sector-RAM writes are queued
// as SD bytes are driven and retired when the DUT strobes HDD_RAM_WE.
module tb_hdd_sd_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] HDD_SECTOR;
    logic        HDD_READ, HDD_WRITE;
    logic [7:0]  HDD_RAM_DO;
    logic        HDD_MOUNTED, HDD_PROTECT;
    logic [8:0]  HDD_RAM_ADDR;
    logic [7:0]  HDD_RAM_DI;
    logic        HDD_RAM_WE;
    logic        img_mounted, img_readonly;
    logic [63:0] img_size;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout, sd_buff_din;
    logic        sd_buff_wr;
    logic        hdd_err;

    int          vectors     = 0;
    int          miscompares = 0;
    int          we_count    = 0;
    logic [16:0] exp_q[$];
    logic [7:0]  tb_ram[512];

    hdd_sd_bridge #(.TIMEOUT_CYCLES(24'd16), .SECT_W(16)) dut (
        .CLK_14M(clk), .reset(reset),
        .HDD_SECTOR(HDD_SECTOR), .HDD_READ(HDD_READ), .HDD_WRITE(HDD_WRITE),
        .HDD_RAM_DO(HDD_RAM_DO), .HDD_MOUNTED(HDD_MOUNTED), .HDD_PROTECT(HDD_PROTECT),
        .HDD_RAM_ADDR(HDD_RAM_ADDR), .HDD_RAM_DI(HDD_RAM_DI), .HDD_RAM_WE(HDD_RAM_WE),
        .img_mounted(img_mounted), .img_readonly(img_readonly), .img_size(img_size),
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_din(sd_buff_din), .sd_buff_wr(sd_buff_wr), .hdd_err(hdd_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Hold the currently driven inputs across n clocks; returns #1 after the last edge.
    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic mountImage(input logic [63:0] size, input logic ro);
        img_mounted  = 1'b1;
        img_size     = size;
        img_readonly = ro;
        applyStimulus(1);
        img_mounted  = 1'b0;
    endtask

    task automatic finishXfer();
        sd_ack = 1'b1;
        applyStimulus(1);
        sd_ack = 1'b0;
        applyStimulus(1);
        HDD_READ  = 1'b0;
        HDD_WRITE = 1'b0;
        applyStimulus(2);
    endtask

    // Every RAM write strobe retires the oldest expected {addr, data} entry.
    always @(negedge clk) begin
        if (HDD_RAM_WE) begin
            we_count++;
            tb_ram[HDD_RAM_ADDR] = HDD_RAM_DI;
            if (exp_q.size() == 0)
                checkOutput("unexpected_we", 64'd1, 64'd0);
            else
                checkOutput("ram_write", {47'd0, HDD_RAM_ADDR, HDD_RAM_DI}, {47'd0, exp_q.pop_front()});
        end
    end

    initial begin
        int n;
        reset = 1'b1;
        HDD_SECTOR = '0; HDD_READ = 0; HDD_WRITE = 0; HDD_RAM_DO = '0;
        img_mounted = 0; img_readonly = 0; img_size = '0;
        sd_ack = 0; sd_buff_addr = '0; sd_buff_dout = '0; sd_buff_wr = 0;
        applyStimulus(3);
        checkOutput("rst_sd_rd", sd_rd, 0);
        checkOutput("rst_sd_wr", sd_wr, 0);
        checkOutput("rst_sd_lba", sd_lba, 0);
        checkOutput("rst_err", hdd_err, 0);
        checkOutput("powerup_mounted", HDD_MOUNTED, 0);
        reset = 1'b0;
        applyStimulus(1);

        // 32 MiB read/write image, then a read of sector 0x123
        mountImage(64'd33554432, 1'b0);
        applyStimulus(1);
        checkOutput("mounted", HDD_MOUNTED, 1);
        checkOutput("protect", HDD_PROTECT, 0);
        HDD_SECTOR = 16'h0123;
        HDD_READ   = 1'b1;
        applyStimulus(1);
        checkOutput("rd_assert", sd_rd, 1);
        checkOutput("rd_lba", sd_lba, 32'h123);
        sd_ack = 1'b1;
        applyStimulus(1);
        checkOutput("rd_drop_on_ack", sd_rd, 0);

        for (int i = 0; i < 512; i++) begin
            sd_buff_addr = 9'(i);
            sd_buff_dout = 8'(i);
            sd_buff_wr   = 1'b1;
            exp_q.push_back({9'(i), 8'(i)});
            applyStimulus(1);
        end
        sd_buff_wr = 1'b0;
        sd_ack     = 1'b0;
        applyStimulus(3);
        checkOutput("queue_drained", exp_q.size(), 0);
        checkOutput("we_count", we_count, 512);
        checkOutput("ram_5", tb_ram[5], 8'd5);
        checkOutput("ram_300", tb_ram[300], 8'd44);
        checkOutput("no_retrigger", sd_rd, 0);
        HDD_READ = 1'b0;
        applyStimulus(2);
        checkOutput("read_err", hdd_err, 0);

        // Last sector of the image is in range
        HDD_SECTOR = 16'hFFFF;
        HDD_READ   = 1'b1;
        applyStimulus(1);
        checkOutput("last_sector_rd", sd_rd, 1);
        checkOutput("last_sector_lba", sd_lba, 32'hFFFF);
        finishXfer();

        // Write op: no RAM writes, SD sees the RAM read data
        HDD_SECTOR = 16'd5;
        HDD_WRITE  = 1'b1;
        applyStimulus(1);
        checkOutput("wr_assert", sd_wr, 1);
        checkOutput("wr_no_rd", sd_rd, 0);
        sd_ack     = 1'b1;
        HDD_RAM_DO = 8'h5A;
        sd_buff_wr = 1'b1;
        applyStimulus(3);
        checkOutput("wr_din", sd_buff_din, 8'h5A);
        checkOutput("wr_no_we", HDD_RAM_WE, 0);
        sd_buff_wr = 1'b0;
        finishXfer();

        // Write to a read-only image
        mountImage(64'd33554432, 1'b1);
        applyStimulus(1);
        checkOutput("ro_protect", HDD_PROTECT, 1);
        HDD_WRITE = 1'b1;
        applyStimulus(1);
        checkOutput("ro_no_wr", sd_wr, 0);
        checkOutput("ro_err", hdd_err, 1);
        applyStimulus(2);
        checkOutput("ro_no_wr_late", sd_wr, 0);
        HDD_WRITE = 1'b0;
        applyStimulus(2);

        // 100-sector image: sector 100 out of range, 99 accepted
        mountImage(64'd51200, 1'b0);
        HDD_SECTOR = 16'd100;
        HDD_READ   = 1'b1;
        applyStimulus(1);
        checkOutput("oor_no_rd", sd_rd, 0);
        checkOutput("oor_err", hdd_err, 1);
        HDD_READ = 1'b0;
        applyStimulus(2);
        HDD_SECTOR = 16'd99;
        HDD_READ   = 1'b1;
        applyStimulus(1);
        checkOutput("inrange_rd", sd_rd, 1);
        checkOutput("inrange_err_clr", hdd_err, 0);
        finishXfer();

        // Timeout: no sd_ack ever
        HDD_SECTOR = 16'd1;
        HDD_READ   = 1'b1;
        applyStimulus(1);
        n = 0;
        while (sd_rd && n < 100) begin
            n++;
            applyStimulus(1);
        end
        checkOutput("timeout_cycles", n, 16);
        checkOutput("timeout_err", hdd_err, 1);
        HDD_READ = 1'b0;
        applyStimulus(2);

        // Reset during XFER, then the held level retriggers
        HDD_SECTOR = 16'd2;
        HDD_READ   = 1'b1;
        applyStimulus(1);
        sd_ack = 1'b1;
        applyStimulus(1);
        reset = 1'b1;
        applyStimulus(1);
        sd_buff_wr = 1'b1;
        #1;
        checkOutput("rst_xfer_we", HDD_RAM_WE, 0);
        checkOutput("rst_xfer_rd", sd_rd, 0);
        checkOutput("rst_xfer_wr", sd_wr, 0);
        checkOutput("rst_keeps_mount", HDD_MOUNTED, 1);
        sd_buff_wr = 1'b0;
        sd_ack     = 1'b0;
        applyStimulus(1);
        reset = 1'b0;
        applyStimulus(1);
        checkOutput("held_level_retrigger", sd_rd, 1);
        finishXfer();

        // Simultaneous read and write edges
        HDD_SECTOR = 16'd7;
        HDD_READ   = 1'b1;
        HDD_WRITE  = 1'b1;
        applyStimulus(1);
        checkOutput("both_rd", sd_rd, 1);
        checkOutput("both_no_wr", sd_wr, 0);
        checkOutput("both_err", hdd_err, 0);
        finishXfer();

        // Image change during REQ aborts the request
        HDD_SECTOR = 16'd3;
        HDD_READ   = 1'b1;
        applyStimulus(1);
        mountImage(64'd51200, 1'b0);
        checkOutput("mount_abort_rd", sd_rd, 0);
        HDD_READ = 1'b0;
        applyStimulus(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hdd_sd_bridge.md
Name: hdd_sd_bridge

Overview:
- Sits directly downstream of the Apple II top's HDD port group; converts its sector read/write requests into block requests on the platform SD/image interface.
- Steers the SD buffer byte stream into and out of the HDD sector RAM.
- Tracks image mount, write-protect and sector count, and aborts requests that would hang or that are illegal.

Parameters:
TIMEOUT_CYCLES, 24'd14_000_000, CLK_14M cycles to wait for sd_ack after issuing a request before aborting (~1 s).
SECT_W, 16, width of the sector number from the core.

Ports:
CLK_14M  in  1  master clock; all logic on posedge
reset  in  1  synchronous, active-high
HDD_SECTOR  in  SECT_W  sector number requested by core
HDD_READ  in  1  read request level from core
HDD_WRITE  in  1  write request level from core
HDD_RAM_DO  in  8  sector RAM read data (write direction)
HDD_MOUNTED  out  1  image present and non-empty
HDD_PROTECT  out  1  image read-only
HDD_RAM_ADDR  out  9  sector RAM byte address
HDD_RAM_DI  out  8  sector RAM write data
HDD_RAM_WE  out  1  sector RAM write strobe
img_mounted  in  1  one-cycle pulse on image change
img_readonly  in  1  valid with img_mounted
img_size  in  64  image size in bytes, valid with img_mounted
sd_lba  out  32  block address
sd_rd  out  1  block read request
sd_wr  out  1  block write request
sd_ack  in  1  high for the duration of the buffer transfer
sd_buff_addr  in  9  buffer byte index
sd_buff_dout  in  8  byte from SD (read)
sd_buff_din  out  8  byte to SD (write)
sd_buff_wr  in  1  byte strobe from SD side
hdd_err  out  1  sticky error: timeout, out-of-range, or write-protected; cleared on next accepted request

Behaviour:
- Reset values: sd_rd=0, sd_wr=0, sd_lba=0, hdd_err=0, state=IDLE.
- HDD_MOUNTED, HDD_PROTECT and the sector-count register are NOT cleared by reset (image persists across warm reset). Power-up value is 0.
- Mount: on img_mounted:
  - mounted <= (img_size != 0)
  - protect <= img_readonly
  - nsect <= img_size[40:9], 32 bits; a partial last sector is dropped.
  - If img_mounted coincides with an active op, the op is aborted to IDLE and sd_rd/sd_wr drop next cycle.
- Request detection: registered previous values of HDD_READ and HDD_WRITE; a request is a rising edge, sampled only in IDLE. Edges outside IDLE are ignored. A level still high after DONE does not retrigger.
- Simultaneous read and write edge: read wins; write is dropped, and hdd_err is not set.
- States:
  - IDLE: on an edge, clear hdd_err and latch lba = zero-extended HDD_SECTOR. Then:
    - if !mounted or lba >= nsect: hdd_err <= 1, go to DONE;
    - else if write and protect: hdd_err <= 1, go to DONE;
    - else assert sd_rd or sd_wr, load the timeout counter, go to REQ.
  - REQ: hold request and sd_lba. On sd_ack=1: deassert sd_rd/sd_wr the same edge, go to XFER. If the counter reaches 0: drop request, hdd_err <= 1, go to DONE.
  - XFER: data pass-through active. On sd_ack falling (registered sample 1 then 0), go to DONE.
  - DONE: wait until HDD_READ=0 and HDD_WRITE=0, then go to IDLE.
- Data path (combinational, 0 latency):
  - HDD_RAM_ADDR = sd_buff_addr.
  - HDD_RAM_DI = sd_buff_dout.
  - HDD_RAM_WE = sd_buff_wr & sd_ack & (state==XFER) & op_is_read.
  - sd_buff_din = HDD_RAM_DO. The sector RAM has 1-cycle read latency; the SD side tolerates this.
  - During a write op, HDD_RAM_WE is 0 throughout.
- Timeout counter: 24 bits, decrements only in REQ, saturates at 0.
- Reset mid-op: any state returns to IDLE next edge with sd_rd=sd_wr=0. The edge detector registers clear, so a held request level produces a new edge after reset.

Decomposition:
- Shared package hdd_pkg holds the state enum (IDLE, REQ, XFER, DONE), the SECTOR_BYTES=512 constant, and the default TIMEOUT_CYCLES.
- No sub-module; the FSM, counter and mount registers are flat in one module (~180 lines).

Test Plan:
1. Mount img_size=32 MiB, readonly=0 -> HDD_MOUNTED=1, HDD_PROTECT=0, nsect=65536. Raise HDD_READ with sector 0x0123 -> sd_lba=0x123 and sd_rd=1 within 1 cycle; sd_rd drops when sd_ack rises.
2. Read transfer: sd_ack high, 512 sd_buff_wr strobes with dout=addr[7:0] -> 512 HDD_RAM_WE pulses, RAM[i]=i[7:0]. After sd_ack falls and HDD_READ=0 -> IDLE, hdd_err=0.
3. Write on readonly image: mount readonly=1, pulse HDD_WRITE -> sd_wr never asserted, hdd_err=1. Drop HDD_WRITE -> IDLE.
4. Out-of-range: nsect=100, HDD_READ with sector 100 -> no sd_rd, hdd_err=1. Sector 99 -> sd_rd=1, hdd_err cleared.
5. Timeout: TIMEOUT_CYCLES=16, never assert sd_ack -> sd_rd high exactly 16 cycles, then 0, hdd_err=1.
6. Reset during XFER -> sd_rd=sd_wr=0 and HDD_RAM_WE=0 next cycle; HDD_MOUNTED stays 1. Simultaneous read+write edge -> only sd_rd asserted.
